// File: rtl/vfb_pkg.sv
// Shared definitions for the RGB565 video-frame stream blocks.
// Holds the FSM state encoding, RGB565 field positions, default geometry
// and thresholds (shared with the frame generators), and a colour matcher.
package vfb_pkg;

  // One-hot receiver states.
  typedef enum logic [2:0] {
    S_SYNC   = 3'b001,
    S_GAP    = 3'b010,
    S_ACTIVE = 3'b100
  } state_t;

  // RGB565 field slices: {R[15:11], G[10:5], B[4:0]}.
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam int         H_ACT_DEF = 800;
  localparam int         V_ACT_DEF = 600;
  localparam logic [4:0] R_TH_DEF  = 5'd24;
  localparam logic [5:0] G_TH_DEF  = 6'd16;
  localparam logic [4:0] B_TH_DEF  = 5'd8;

  // Red-object test: strong red, weak green and blue.
  function automatic logic is_red(input logic [15:0] p, input logic [4:0] r_th,
                                  input logic [5:0] g_th, input logic [4:0] b_th);
    return (p[R_MSB:R_LSB] >= r_th) && (p[G_MSB:G_LSB] < g_th) &&
           (p[B_MSB:B_LSB] < b_th);
  endfunction

endpackage

// File: rtl/vfb_bbox_acc.sv
// Bounding-box accumulator for matching pixels within one frame.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        return accumulators to empty (min all-ones, max 0, no hit)
//   accept       an in-geometry pixel is being taken this cycle
//   match        that pixel passes the colour test
//   x, y         raster coordinates of the pixel
//   x_min..y_max running bounding box; hit = at least one match seen
module vfb_bbox_acc #(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           accept,
  input  logic           match,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [X_W-1:0] x_min,
  output logic [X_W-1:0] x_max,
  output logic [Y_W-1:0] y_min,
  output logic [Y_W-1:0] y_max,
  output logic           hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min <= '1;
      x_max <= '0;
      y_min <= '1;
      y_max <= '0;
      hit   <= 1'b0;
    end else if (clear) begin
      x_min <= '1;
      x_max <= '0;
      y_min <= '1;
      y_max <= '0;
      hit   <= 1'b0;
    end else if (accept && match) begin
      if (x < x_min) x_min <= x;
      if (x > x_max) x_max <= x;
      if (y < y_min) y_min <= y;
      if (y > y_max) y_max <= y;
      hit <= 1'b1;
    end
  end

endmodule

// File: rtl/vfb_rx_check.sv
// Sink of the RGB565 frame stream: rebuilds raster coordinates, checks the
// pixel count of each frame against H_ACT*V_ACT, and tracks the bounding box
// of red pixels. Per-frame results are published with a one-cycle frame_done.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   rgb_in            pixel {R,G,B} 5/6/5
//   vs_n              low = inter-frame gap, high = frame active
//   clken             pixel valid (ignored while vs_n low)
//   frame_done        strobe; all result outputs update on the same edge
//   frame_ok/underrun/overrun  count equal / short / long vs H_ACT*V_ACT
//   pix_count         pixels accepted in last frame (saturating)
//   box_valid, box_*  bounding box of matches in last frame
module vfb_rx_check
  import vfb_pkg::*;
#(
  parameter int         H_ACT = H_ACT_DEF,
  parameter int         V_ACT = V_ACT_DEF,
  parameter int         X_W   = 10,
  parameter int         Y_W   = 10,
  parameter int         CNT_W = 20,
  parameter logic [4:0] R_TH  = R_TH_DEF,
  parameter logic [5:0] G_TH  = G_TH_DEF,
  parameter logic [4:0] B_TH  = B_TH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      rgb_in,
  input  logic             vs_n,
  input  logic             clken,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             underrun,
  output logic             overrun,
  output logic [CNT_W-1:0] pix_count,
  output logic             box_valid,
  output logic [X_W-1:0]   box_x_min,
  output logic [X_W-1:0]   box_x_max,
  output logic [Y_W-1:0]   box_y_min,
  output logic [Y_W-1:0]   box_y_max
);

  localparam logic [CNT_W-1:0] TOTAL  = CNT_W'(H_ACT * V_ACT);
  localparam logic [X_W-1:0]   X_LAST = X_W'(H_ACT - 1);
  localparam logic [Y_W-1:0]   Y_LAST = Y_W'(V_ACT - 1);

  state_t           state, state_nxt;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [CNT_W-1:0] count;
  logic             accept, eof, clr, in_geo, pix_match;
  logic [X_W-1:0]   acc_x_min, acc_x_max;
  logic [Y_W-1:0]   acc_y_min, acc_y_max;
  logic             acc_hit;

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC:   if (!vs_n) state_nxt = S_GAP;
      S_GAP:    if (vs_n)  state_nxt = S_ACTIVE;
      S_ACTIVE: if (!vs_n) state_nxt = S_GAP;
      default:  state_nxt = S_SYNC;
    endcase
  end

  always_comb begin
    accept = (state == S_ACTIVE) && vs_n && clken;
    eof    = (state == S_ACTIVE) && !vs_n;
    // Counters stay cleared outside an active frame, so each frame starts at 0.
    clr    = (state != S_ACTIVE);
  end

  assign in_geo    = (count < TOTAL);
  assign pix_match = is_red(rgb_in, R_TH, G_TH, B_TH);

  // ---- raster position and pixel count ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      count <= '0;
    end else if (clr) begin
      x     <= '0;
      y     <= '0;
      count <= '0;
    end else if (accept) begin
      if (count != '1) count <= count + 1'b1;
      // Surplus pixels past the frame size leave the position frozen.
      if (in_geo) begin
        if (x == X_LAST) begin
          x <= '0;
          if (y != Y_LAST) y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  vfb_bbox_acc #(.X_W(X_W), .Y_W(Y_W)) u_bbox (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clr),
    .accept (accept && in_geo),
    .match  (pix_match),
    .x      (x),
    .y      (y),
    .x_min  (acc_x_min),
    .x_max  (acc_x_max),
    .y_min  (acc_y_min),
    .y_max  (acc_y_max),
    .hit    (acc_hit)
  );

  // ---- per-frame result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
      pix_count  <= '0;
      box_valid  <= 1'b0;
      box_x_min  <= '1;
      box_x_max  <= '0;
      box_y_min  <= '1;
      box_y_max  <= '0;
    end else begin
      frame_done <= eof;
      if (eof) begin
        frame_ok  <= (count == TOTAL);
        underrun  <= (count <  TOTAL);
        overrun   <= (count >  TOTAL);
        pix_count <= count;
        box_valid <= acc_hit;
        box_x_min <= acc_hit ? acc_x_min : '1;
        box_x_max <= acc_hit ? acc_x_max : '0;
        box_y_min <= acc_hit ? acc_y_min : '1;
        box_y_max <= acc_hit ? acc_y_max : '0;
      end
    end
  end

endmodule

// File: tb/tb_vfb_rx_check.sv
// Scoreboard bench for vfb_rx_check with an 8x4 frame geometry.
module tb_vfb_rx_check;
  localparam int H = 8;
  localparam int V = 4;
  localparam int TOT = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rgb_in = '0;
  logic        vs_n = 1'b0;
  logic        clken = 1'b0;
  logic        frame_done, frame_ok, underrun, overrun, box_valid;
  logic [19:0] pix_count;
  logic [9:0]  box_x_min, box_x_max, box_y_min, box_y_max;

  typedef logic [15:0] pq_t[$];
  typedef struct {
    int          done_cyc;
    logic        ok, un, ov, bv;
    logic [19:0] cnt;
    logic [9:0]  xmin, xmax, ymin, ymax;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  vfb_rx_check #(.H_ACT(H), .V_ACT(V)) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .vs_n(vs_n), .clken(clken),
    .frame_done(frame_done), .frame_ok(frame_ok), .underrun(underrun),
    .overrun(overrun), .pix_count(pix_count), .box_valid(box_valid),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: the i-th accepted pixel sits at (i % H, i / H) if i < H*V.
  function automatic exp_t model(input pq_t px, input int dc);
    exp_t e;
    int   n;
    n = px.size();
    e.done_cyc = dc;
    e.cnt = 20'(n);
    e.ok = (n == TOT);
    e.un = (n < TOT);
    e.ov = (n > TOT);
    e.bv = 1'b0;
    e.xmin = 10'h3FF; e.xmax = '0; e.ymin = 10'h3FF; e.ymax = '0;
    for (int i = 0; i < n && i < TOT; i++) begin
      logic [15:0] p;
      int r, g, b, xx, yy;
      p = px[i];
      r = int'(p[15:11]); g = int'(p[10:5]); b = int'(p[4:0]);
      xx = i % H; yy = i / H;
      if (r >= 24 && g < 16 && b < 8) begin
        e.bv = 1'b1;
        if (xx < int'(e.xmin)) e.xmin = 10'(xx);
        if (xx > int'(e.xmax)) e.xmax = 10'(xx);
        if (yy < int'(e.ymin)) e.ymin = 10'(yy);
        if (yy > int'(e.ymax)) e.ymax = 10'(yy);
      end
    end
    return e;
  endfunction

  // Monitor: every frame_done must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.done_cyc);
        chk("pix_count", pix_count, mon_e.cnt);
        chk("frame_ok", frame_ok, mon_e.ok);
        chk("underrun", underrun, mon_e.un);
        chk("overrun", overrun, mon_e.ov);
        chk("box_valid", box_valid, mon_e.bv);
        chk("box_x_min", box_x_min, mon_e.xmin);
        chk("box_x_max", box_x_max, mon_e.xmax);
        chk("box_y_min", box_y_min, mon_e.ymin);
        chk("box_y_max", box_y_max, mon_e.ymax);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_ok"}, frame_ok, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_pix_count"}, pix_count, 0);
    chk({tag, "_box_valid"}, box_valid, 0);
    chk({tag, "_box_x_min"}, box_x_min, 10'h3FF);
    chk({tag, "_box_x_max"}, box_x_max, 0);
    chk({tag, "_box_y_min"}, box_y_min, 10'h3FF);
    chk({tag, "_box_y_max"}, box_y_max, 0);
  endtask

  // idle < 0 : random 0..2 idle cycles before each pixel.
  // The first vs_n-high cycle carries a red pixel that must not be taken;
  // the first gap cycle always has clken high to prove it is ignored.
  task automatic send_frame(input pq_t px, input int idle, input int gap);
    int k;
    vs_n = 1'b1; clken = 1'b1; rgb_in = 16'hF800;
    tick();
    foreach (px[i]) begin
      k = (idle < 0) ? int'($urandom_range(0, 2)) : idle;
      repeat (k) begin clken = 1'b0; rgb_in = 16'($urandom); tick(); end
      clken = 1'b1; rgb_in = px[i];
      tick();
    end
    vs_n = 1'b0; clken = 1'b1; rgb_in = 16'hF800;
    sb.push_back(model(px, cyc + 1));
    tick();
    repeat (gap - 1) begin clken = 1'($urandom_range(0, 1)); tick(); end
    clken = 1'b0;
  endtask

  function automatic logic [15:0] rand_pix();
    case ($urandom_range(0, 3))
      0: return 16'hF800;
      1: return 16'h001F;
      2: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    pq_t px;
    int  n, wait_cyc;

    repeat (3) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: full red frame, clken alternating
    px = {};
    for (int i = 0; i < TOT; i++) px.push_back(16'hF800);
    send_frame(px, 1, 2);

    // 2: red block x=2..5,y=1..2 on blue; white row does not match
    px = {};
    for (int i = 0; i < TOT; i++) begin
      int xx, yy;
      xx = i % H; yy = i / H;
      if (xx >= 2 && xx <= 5 && yy >= 1 && yy <= 2) px.push_back(16'hF800);
      else if (yy == 3)                            px.push_back(16'hFFFF);
      else                                         px.push_back(16'h001F);
    end
    send_frame(px, 0, 2);

    // 3: short frame, single match at (1,1)
    px = {};
    for (int i = 0; i < 10; i++) px.push_back(i == 9 ? 16'hF800 : 16'h001F);
    send_frame(px, 0, 2);

    // 4: 35 pixels, surplus red pixels outside geometry
    px = {};
    for (int i = 0; i < 35; i++) px.push_back(i >= 32 ? 16'hF800 : 16'h001F);
    send_frame(px, 0, 2);

    // zero-pixel frame
    px = {};
    send_frame(px, 0, 2);

    // 5: reset mid-frame, stream keeps running
    vs_n = 1'b1; tick();
    for (int i = 0; i < 12; i++) begin clken = 1'b1; rgb_in = 16'hF800; tick(); end
    rst_n = 1'b0;
    tick();
    check_cleared("midreset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin clken = 1'b1; rgb_in = 16'hF800; tick(); end
    vs_n = 1'b0; clken = 1'b0;
    repeat (2) tick();
    px = {};
    for (int i = 0; i < TOT; i++) px.push_back(rand_pix());
    send_frame(px, 0, 2);

    // 6: back-to-back frames with a one-cycle gap
    for (int f = 0; f < 2; f++) begin
      px = {};
      for (int i = 0; i < TOT; i++) px.push_back(rand_pix());
      send_frame(px, 0, 1);
    end

    // random frames
    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(0, 2))
        0: n = TOT;
        1: n = 0;
        default: n = int'($urandom_range(1, 40));
      endcase
      px = {};
      for (int i = 0; i < n; i++) px.push_back(rand_pix());
      send_frame(px, -1, int'($urandom_range(1, 3)));
    end

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 20) begin tick(); wait_cyc++; end
    chk("missing_frame_done", sb.size(), 0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
